// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E-stage decode and the multiply/divide unit.
// Signal names follow the pipeline's existing MDOp/Start/Busy/HI/LO naming.
interface md_unit_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, MDOp, Start, input Busy, HI, LO);
  modport slave  (input A, B, MDOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage of the MIPS pipeline.
// Operands are latched at accept; results are written on the final busy edge.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            sgn_q, sgn_d;

  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] a_mag, b_mag, quo_mag, rem_mag, quo, rem;

  // Signed divide done on magnitudes so INT_MIN / -1 wraps to INT_MIN with no special case.
  always_comb begin
    a_ext   = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext   = {{32{sgn_q & b_q[31]}}, b_q};
    prod    = a_ext * b_ext;
    a_mag   = (sgn_q && a_q[31]) ? -a_q : a_q;
    b_mag   = (sgn_q && b_q[31]) ? -b_q : b_q;
    quo_mag = (b_mag != '0) ? (a_mag / b_mag) : '0;
    rem_mag = (b_mag != '0) ? (a_mag % b_mag) : '0;
    quo     = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_mag : quo_mag;
    rem     = (sgn_q && a_q[31]) ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (bus.Start) begin
          case (bus.MDOp)
            3'd1, 3'd2: begin
              state_d = StMult;
              cnt_d   = CntW'(MULT_CYCLES);
              a_d     = bus.A;
              b_d     = bus.B;
              sgn_d   = (bus.MDOp == 3'd1);
            end
            3'd3, 3'd4: begin
              state_d = StDiv;
              cnt_d   = CntW'(DIV_CYCLES);
              a_d     = bus.A;
              b_d     = bus.B;
              sgn_d   = (bus.MDOp == 3'd3);
            end
            3'd5:    hi_d = bus.A;
            3'd6:    lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StMult, StDiv: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (state_q == StMult) begin
            {hi_d, lo_d} = prod;
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy = (state_q != StIdle);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: cycle-level reference model checked every cycle, plus directed
// vectors with hand-computed HI/LO values and busy-length checks.
module tb_md_unit;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: remaining busy cycles plus a pending result applied when it hits zero.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          p_wr = 1'b0;

  always @(posedge clk) begin
    longint sa, sb, r64;
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.Start) begin
      case (bus.MDOp)
        3'd1, 3'd3: begin sa = $signed(bus.A); sb = $signed(bus.B); end
        default:    begin sa = {32'b0, bus.A}; sb = {32'b0, bus.B}; end
      endcase
      case (bus.MDOp)
        3'd1, 3'd2: begin
          r64    = sa * sb;
          p_hi   = r64[63:32];
          p_lo   = r64[31:0];
          p_wr   = 1'b1;
          m_left = 5;
        end
        3'd3, 3'd4: begin
          p_wr   = (sb != 0);
          m_left = 10;
          if (sb != 0) begin
            r64  = sa / sb;
            p_lo = r64[31:0];
            r64  = sa % sb;
            p_hi = r64[31:0];
          end
        end
        3'd5:    m_hi = bus.A;
        3'd6:    m_lo = bus.A;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_busy", {31'b0, bus.Busy}, {31'b0, (m_left > 0)});
      chk("cyc_hi", bus.HI, m_hi);
      chk("cyc_lo", bus.LO, m_lo);
    end
  end

  // Drive an op at the current negedge for one cycle, then scramble operands.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.MDOp  = 3'd0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Count cycles Busy is seen high (including the current one); bounded.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.Busy === 1'b1 && cyc < 100) begin
      cyc = cyc + 1;
      @(negedge clk);
    end
    if (cyc >= 100) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  int n;

  initial begin
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_on = 1'b1;
    chk("rst_busy", {31'b0, bus.Busy}, 32'd0);
    chk("rst_hi", bus.HI, 32'h0);
    chk("rst_lo", bus.LO, 32'h0);

    // mult -3 * 5
    issue(3'd1, 32'hFFFF_FFFD, 32'd5);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFF1);

    // multu issued back-to-back on the first idle cycle
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", bus.HI, 32'h0000_0001);
    chk("multu_lo", bus.LO, 32'hFFFF_FFFE);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);

    // divu by zero leaves HI/LO alone
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    chk("div0_cycles", n, 32'd10);
    chk("div0_hi", bus.HI, 32'hFFFF_FFFF);
    chk("div0_lo", bus.LO, 32'hFFFF_FFFD);

    // INT_MIN / -1
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", bus.LO, 32'h8000_0000);
    chk("ovf_hi", bus.HI, 32'h0000_0000);

    // div 7 / -2 and divu 100 / 7
    issue(3'd3, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    chk("divn_lo", bus.LO, 32'hFFFF_FFFD);
    chk("divn_hi", bus.HI, 32'h0000_0001);
    issue(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lo", bus.LO, 32'd14);
    chk("divu_hi", bus.HI, 32'd2);

    // mthi / mtlo
    issue(3'd5, 32'h1234_5678, 32'h0);
    chk("mthi_busy", {31'b0, bus.Busy}, 32'd0);
    chk("mthi_hi", bus.HI, 32'h1234_5678);
    issue(3'd6, 32'hCAFE_BABE, 32'h0);
    chk("mtlo_lo", bus.LO, 32'hCAFE_BABE);
    chk("mtlo_hi", bus.HI, 32'h1234_5678);

    // Start while busy is dropped
    issue(3'd1, 32'd2, 32'd3);
    issue(3'd4, 32'd9, 32'd2);
    wait_idle(n);
    chk("ign_cycles", n, 32'd4);
    chk("ign_hi", bus.HI, 32'd0);
    chk("ign_lo", bus.LO, 32'd6);
    repeat (12) @(negedge clk);
    chk("ign_late_lo", bus.LO, 32'd6);

    // reset mid-div aborts with no later write
    issue(3'd4, 32'd100, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'b0, bus.Busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    repeat (15) @(negedge clk);
    chk("abort_late_lo", bus.LO, 32'd0);
    chk("abort_late_hi", bus.HI, 32'd0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
